pf_tile_engine: RTL and testbench
=================================

PF_TILE_ENGINE -- requirements
Module: pf_tile_engine

Interface
REQ-001 Parameter TILE_BITS, default 4, log2 tile edge in pixels (tile is 2^TILE_BITS square).
REQ-002 Parameter MAP_BITS, default 4, log2 map edge in tiles; TILE_BITS+MAP_BITS SHALL equal 8, elaboration error otherwise.
REQ-003 Parameter PIX_W, default 1, bits per pixel (1..4).
REQ-004 Parameter NUM_CH, default 1, number of car-video collision channels (1..8).
REQ-005 Clk6 in 1: the single clock; all state changes on its rising edge.
REQ-006 Reset_n in 1: asynchronous, active-low reset.
REQ-007 BD in 8: CPU data bus, scroll load value.
REQ-008 PHP_Load_n / PVP_Load_n in 1 each: active-low horizontal / vertical scroll load strobes.
REQ-009 LineStart, FrameStart in 1 each: one-clock pulses at line start and frame start.
REQ-010 Active in 1: visible pixel qualifier; Window in 1: playfield window enable.
REQ-011 MapAdr out 2*MAP_BITS; MapQ in 8: synchronous map RAM, data one clock after address.
REQ-012 RomAdr out 4+TILE_BITS; RomQ in (2^TILE_BITS)*PIX_W: synchronous tile ROM, one clock latency, pixel 0 in LSBs.
REQ-013 CarVideo in NUM_CH; Clear_n in NUM_CH: per-channel car video and active-low flag clear.
REQ-014 Pix out PIX_W; PCC out 2; Pfld out 1; PfWndo out 1; CrashFlag, SkidFlag out NUM_CH each.

Function
REQ-015 Horizontal counter HX (8 bit): PHP_Load_n low loads scroll register SX <= BD; LineStart loads HX <= SX; else Active increments HX, mod 256.
REQ-016 Vertical counter VY (8 bit): PVP_Load_n low loads SY <= BD; FrameStart loads VY <= SY; else LineStart with Active-line flag set increments VY, mod 256.
REQ-017 Load strobe and simultaneous LineStart/FrameStart: counter takes the OLD SX/SY; the new value applies next line/frame.
REQ-018 Stage 0: MapAdr = {VY[7:TILE_BITS], HX[7:TILE_BITS]}; fine x/y, Active, Window pipelined alongside.
REQ-019 Stage 1: RomAdr = {MapQ[3:0], fine y}; attributes MapQ[7:6] (colour), MapQ[5] (skid), MapQ[4] (crash) registered.
REQ-020 Stage 2: pixel = RomQ field selected by stage-2 fine x; registered into Pix, PCC, attributes.
REQ-021 Total latency HX/VY sample to Pix/Pfld: exactly 3 clocks; one pixel per clock, no bubbles across tile boundaries.
REQ-022 PfWndo = delayed Window & delayed Active; Pix forced 0 and Pfld 0 when PfWndo is 0.
REQ-023 Pfld = 1 when Pix non-zero and PfWndo = 1.
REQ-024 Map wraps: tile column/row wrap mod 2^MAP_BITS via counter wrap; no edge special case.
REQ-025 Per channel i: Pfld & CarVideo[i] & crash attr sets CrashFlag[i]; Pfld & CarVideo[i] & skid attr & ~crash attr sets SkidFlag[i].
REQ-026 Flags sticky until Clear_n[i] low; set and clear in same clock: set wins.
REQ-027 CarVideo compared in the same clock as Pix/Pfld (caller aligns car video to output stage).

Reset
REQ-028 Reset_n low: SX, SY, HX, VY, all pipeline registers, Pix, PCC, Pfld, PfWndo, CrashFlag, SkidFlag = 0, asynchronously.
REQ-029 Reset mid-line: outputs 0 immediately; first valid pixel 3 clocks after first Active following release.

Verification
REQ-030 SX=0x00, map tile (0,0)=0x01, ROM row 0 = 0x0001, Active from LineStart -> Pix=1, Pfld=1 exactly 3 clocks after LineStart, Pix=0 next 15 clocks.
REQ-031 SX=0xFE, Active 4 clocks -> MapAdr column sequence F,F,0,0 and Pix continuous without gap across wrap.
REQ-032 PHP_Load_n with BD=0x20 coincident with LineStart -> HX uses previous SX; next LineStart HX=0x20.
REQ-033 NUM_CH=2, tile attr crash=1, CarVideo=01 during Pfld=1 -> CrashFlag=01, SkidFlag=00; Clear_n[0] low with overlap still active -> CrashFlag[0] stays 1.
REQ-034 Attr skid=1 crash=0, CarVideo=10 -> SkidFlag=10; Clear_n=01 with no overlap -> SkidFlag=00 next clock.
REQ-035 Window=0 with non-zero tile -> Pix=0, Pfld=0, no flag sets; Reset_n low mid-frame -> all outputs 0 same clock.

Source files
------------

// File: rtl/pf_tile_engine.sv
`default_nettype none
// ============================================================================
// Module   : pf_tile_engine
// Brief    : Scrolling tile playfield: map/tile-ROM pixel pipeline with
//            per-channel crash/skid collision flags.
// Revision : 1.0  initial release
// ============================================================================
module pf_tile_engine #(
    parameter int TILE_BITS = 4,
    parameter int MAP_BITS  = 4,
    parameter int PIX_W     = 1,
    parameter int NUM_CH    = 1
) (
    input  logic                                 i_clk6,
    input  logic                                 i_reset_n,
    input  logic [7:0]                           i_bd,
    input  logic                                 i_php_load_n,
    input  logic                                 i_pvp_load_n,
    input  logic                                 i_line_start,
    input  logic                                 i_frame_start,
    input  logic                                 i_active,
    input  logic                                 i_window,
    output logic [2*MAP_BITS-1:0]                o_map_adr,
    input  logic [7:0]                           i_map_q,
    output logic [4+TILE_BITS-1:0]               o_rom_adr,
    input  logic [(2**TILE_BITS)*PIX_W-1:0]      i_rom_q,
    input  logic [NUM_CH-1:0]                    i_car_video,
    input  logic [NUM_CH-1:0]                    i_clear_n,
    output logic [PIX_W-1:0]                     o_pix,
    output logic [1:0]                           o_pcc,
    output logic                                 o_pfld,
    output logic                                 o_pf_wndo,
    output logic [NUM_CH-1:0]                    o_crash_flag,
    output logic [NUM_CH-1:0]                    o_skid_flag
);

    localparam int c_TILE_PIX = 2**TILE_BITS;

    if (TILE_BITS + MAP_BITS != 8) begin : g_bad_geometry
        $error("pf_tile_engine: TILE_BITS + MAP_BITS must equal 8");
    end
    if (PIX_W < 1 || PIX_W > 4) begin : g_bad_pix_w
        $error("pf_tile_engine: PIX_W must be 1..4");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("pf_tile_engine: NUM_CH must be 1..8");
    end

    logic [7:0]             r_sx, r_sy, r_hx, r_vy;
    logic                   r_line_act;
    logic [TILE_BITS-1:0]   r_s1_fx, r_s1_fy, r_s2_fx;
    logic                   r_s1_act, r_s1_win, r_s2_act, r_s2_win;
    logic [1:0]             r_s2_col;
    logic                   r_s2_skid, r_s2_crash;
    logic [PIX_W-1:0]       r_pix;
    logic [1:0]             r_pcc;
    logic                   r_pfld, r_pf_wndo, r_crash_attr, r_skid_attr;
    logic [NUM_CH-1:0]      r_crash_flag, r_skid_flag;
    logic [PIX_W-1:0]       w_pix_raw;
    logic                   w_wndo;
    logic [NUM_CH-1:0]      w_crash_set, w_skid_set;

    // Scroll registers and counters; a load coincident with a line/frame
    // start leaves the counter reading the previous scroll value.
    always_ff @(posedge i_clk6 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sx       <= 8'd0;
            r_sy       <= 8'd0;
            r_hx       <= 8'd0;
            r_vy       <= 8'd0;
            r_line_act <= 1'b0;
        end else begin
            if (!i_php_load_n) r_sx <= i_bd;
            if (!i_pvp_load_n) r_sy <= i_bd;
            if (i_line_start)  r_hx <= r_sx;
            else if (i_active) r_hx <= r_hx + 8'd1;
            if (i_frame_start) begin
                r_vy       <= r_sy;
                r_line_act <= 1'b0;
            end else if (i_line_start) begin
                if (r_line_act) r_vy <= r_vy + 8'd1;
                r_line_act <= 1'b0;
            end else if (i_active) begin
                r_line_act <= 1'b1;
            end
        end
    end

    assign o_map_adr = {r_vy[7:TILE_BITS], r_hx[7:TILE_BITS]};
    assign o_rom_adr = {i_map_q[3:0], r_s1_fy};

    always_comb begin
        w_pix_raw = '0;
        for (int i = 0; i < c_TILE_PIX; i++) begin
            if (r_s2_fx == TILE_BITS'(i)) w_pix_raw = i_rom_q[i*PIX_W +: PIX_W];
        end
    end

    assign w_wndo = r_s2_act & r_s2_win;

    always_ff @(posedge i_clk6 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s1_fx      <= '0;
            r_s1_fy      <= '0;
            r_s1_act     <= 1'b0;
            r_s1_win     <= 1'b0;
            r_s2_fx      <= '0;
            r_s2_act     <= 1'b0;
            r_s2_win     <= 1'b0;
            r_s2_col     <= 2'd0;
            r_s2_skid    <= 1'b0;
            r_s2_crash   <= 1'b0;
            r_pix        <= '0;
            r_pcc        <= 2'd0;
            r_pfld       <= 1'b0;
            r_pf_wndo    <= 1'b0;
            r_crash_attr <= 1'b0;
            r_skid_attr  <= 1'b0;
        end else begin
            r_s1_fx      <= r_hx[TILE_BITS-1:0];
            r_s1_fy      <= r_vy[TILE_BITS-1:0];
            r_s1_act     <= i_active;
            r_s1_win     <= i_window;
            r_s2_fx      <= r_s1_fx;
            r_s2_act     <= r_s1_act;
            r_s2_win     <= r_s1_win;
            r_s2_col     <= i_map_q[7:6];
            r_s2_skid    <= i_map_q[5];
            r_s2_crash   <= i_map_q[4];
            r_pix        <= w_wndo ? w_pix_raw : '0;
            r_pfld       <= w_wndo & (|w_pix_raw);
            r_pf_wndo    <= w_wndo;
            r_pcc        <= r_s2_col;
            r_crash_attr <= r_s2_crash;
            r_skid_attr  <= r_s2_skid;
        end
    end

    assign w_crash_set = {NUM_CH{r_pfld & r_crash_attr}} & i_car_video;
    assign w_skid_set  = {NUM_CH{r_pfld & r_skid_attr & ~r_crash_attr}} & i_car_video;

    // Sticky flags; a set in the same clock as a clear takes priority.
    always_ff @(posedge i_clk6 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_crash_flag <= '0;
            r_skid_flag  <= '0;
        end else begin
            r_crash_flag <= w_crash_set | (r_crash_flag & i_clear_n);
            r_skid_flag  <= w_skid_set  | (r_skid_flag  & i_clear_n);
        end
    end

    assign o_pix        = r_pix;
    assign o_pcc        = r_pcc;
    assign o_pfld       = r_pfld;
    assign o_pf_wndo    = r_pf_wndo;
    assign o_crash_flag = r_crash_flag;
    assign o_skid_flag  = r_skid_flag;

endmodule
`default_nettype wire

// File: tb/tb_pf_tile_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_pf_tile_engine
// Brief    : Scoreboard bench for pf_tile_engine (PIX_W=2, NUM_CH=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_pf_tile_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  bd = 8'd0;
    logic        php_n = 1'b1, pvp_n = 1'b1, ls = 1'b0, fs = 1'b0;
    logic        act = 1'b0, win = 1'b0;
    logic [7:0]  map_adr, map_q = 8'd0;
    logic [7:0]  rom_adr;
    logic [31:0] rom_q = 32'd0;
    logic [1:0]  car = 2'b00, clr = 2'b11;
    logic [1:0]  pix, pcc, crash, skid;
    logic        pfld, wndo;

    pf_tile_engine #(.TILE_BITS(4), .MAP_BITS(4), .PIX_W(2), .NUM_CH(2)) dut (
        .i_clk6(clk), .i_reset_n(rst_n), .i_bd(bd),
        .i_php_load_n(php_n), .i_pvp_load_n(pvp_n),
        .i_line_start(ls), .i_frame_start(fs), .i_active(act), .i_window(win),
        .o_map_adr(map_adr), .i_map_q(map_q), .o_rom_adr(rom_adr), .i_rom_q(rom_q),
        .i_car_video(car), .i_clear_n(clr),
        .o_pix(pix), .o_pcc(pcc), .o_pfld(pfld), .o_pf_wndo(wndo),
        .o_crash_flag(crash), .o_skid_flag(skid)
    );

    always #5 clk = ~clk;

    logic [7:0]  map_mem [256];
    logic [31:0] rom_mem [256];
    always @(posedge clk) begin
        map_q <= map_mem[map_adr];
        rom_q <= rom_mem[rom_adr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc; logic [1:0] pix; logic pfld; logic wndo;
        logic [1:0] pcc; logic crash; logic skid;
    } exp_t;
    typedef struct { int cyc; logic [7:0] adr; } adr_t;
    exp_t oq[$];
    adr_t mq[$];

    int   n_checks = 0, n_pass = 0;
    bit   in_reset = 1'b1;
    logic [1:0] exp_crash = 2'b00, exp_skid = 2'b00;

    // Reference model state: plain integer counters following the scroll rules.
    int m_hx, m_vy, m_sx, m_sy;
    bit m_lflag;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, want);
    endtask

    always @(negedge clk) begin
        exp_t e;
        adr_t m;
        if (!in_reset) begin
            if (mq.size() > 0 && mq[0].cyc == cyc) begin
                m = mq.pop_front();
                chk("map_adr", map_adr, m.adr);
            end
            if (oq.size() > 0 && oq[0].cyc == cyc) begin
                e = oq.pop_front();
                chk("pix", pix, e.pix);
                chk("pfld", pfld, e.pfld);
                chk("pf_wndo", wndo, e.wndo);
                chk("pcc", pcc, e.pcc);
                chk("crash_flag", crash, exp_crash);
                chk("skid_flag", skid, exp_skid);
                exp_crash = ({2{e.pfld & e.crash}} & car) | (exp_crash & clr);
                exp_skid  = ({2{e.pfld & e.skid & ~e.crash}} & car) | (exp_skid & clr);
            end
        end
    end

    task automatic idle_inputs();
        php_n = 1'b1; pvp_n = 1'b1; ls = 1'b0; fs = 1'b0;
        act = 1'b0; win = 1'b0; car = 2'b00; clr = 2'b11;
    endtask

    // Issue one clock of the current inputs and queue its expected response.
    task automatic step();
        exp_t e;
        int tidx, nsx, nsy;
        logic [7:0]  t;
        logic [31:0] row;
        logic [1:0]  p;
        bit vis;
        tidx = (m_vy / 16) * 16 + (m_hx / 16);
        t    = map_mem[tidx];
        row  = rom_mem[(t % 16) * 16 + (m_vy % 16)];
        p    = 2'((row >> ((m_hx % 16) * 2)) & 32'd3);
        vis  = act && win;
        mq.push_back('{cyc: cyc, adr: 8'(tidx)});
        e.cyc = cyc + 3; e.pix = vis ? p : 2'd0; e.pfld = vis && (p != 0);
        e.wndo = vis; e.pcc = t[7:6]; e.crash = t[4]; e.skid = t[5];
        oq.push_back(e);
        nsx = php_n ? m_sx : int'(bd);
        nsy = pvp_n ? m_sy : int'(bd);
        if (ls) m_hx = m_sx;
        else if (act) m_hx = (m_hx + 1) % 256;
        if (fs) begin m_vy = m_sy; m_lflag = 0; end
        else if (ls) begin if (m_lflag) m_vy = (m_vy + 1) % 256; m_lflag = 0; end
        else if (act) m_lflag = 1;
        m_sx = nsx; m_sy = nsy;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_reset = 1'b1;
        oq.delete(); mq.delete();
        exp_crash = 2'b00; exp_skid = 2'b00;
        m_hx = 0; m_vy = 0; m_sx = 0; m_sy = 0; m_lflag = 0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; in_reset = 1'b0;
        for (int i = 0; i < 3; i++) oq.push_back('{cyc: cyc + i, default: '0});
    endtask

    task automatic load_sx(input logic [7:0] v);
        bd = v; php_n = 1'b0; step(); php_n = 1'b1;
    endtask
    task automatic load_sy(input logic [7:0] v);
        bd = v; pvp_n = 1'b0; step(); pvp_n = 1'b1;
    endtask
    task automatic frame();
        fs = 1'b1; step(); fs = 1'b0;
    endtask
    task automatic line(input int n, input logic w);
        ls = 1'b1; act = 1'b0; step(); ls = 1'b0;
        win = w;
        for (int i = 0; i < n; i++) begin act = 1'b1; step(); end
        act = 1'b0;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            map_mem[i] = 8'($urandom);
            rom_mem[i] = $urandom;
        end
        map_mem[0] = 8'h01;
        rom_mem[16] = 32'h0000_0001;
        for (int c = 0; c < 16; c++) begin
            map_mem[16 + c] = 8'hD2;
            map_mem[32 + c] = 8'h62;
            rom_mem[32 + c] = 32'h5555_5555;
        end

        do_reset();
        idle(4);

        // Single lit pixel at the first visible position.
        load_sx(8'h00); load_sy(8'h00); frame();
        line(16, 1'b1); idle(4);

        // Horizontal wrap through column F to column 0.
        load_sx(8'hFE);
        line(4, 1'b1); idle(4);

        // Scroll load coincident with line start.
        bd = 8'h20; php_n = 1'b0; ls = 1'b1; step();
        php_n = 1'b1; ls = 1'b0; win = 1'b1;
        for (int i = 0; i < 3; i++) begin act = 1'b1; step(); end
        act = 1'b0;
        line(3, 1'b1); idle(4);

        // Crash row, clear held low on channel 0 while overlap continues.
        load_sy(8'h10); frame();
        car = 2'b01;
        ls = 1'b1; step(); ls = 1'b0; win = 1'b1;
        for (int i = 0; i < 8; i++) begin
            act = 1'b1; clr = (i >= 5) ? 2'b10 : 2'b11; step();
        end
        act = 1'b0; clr = 2'b11; idle(5);
        chk("crash_after_overlap", crash, 2'b01);
        chk("skid_after_crash_row", skid, 2'b00);
        car = 2'b00; clr = 2'b00; step(); clr = 2'b11;
        chk("crash_cleared", crash, 2'b00);

        // Skid row on channel 1, then clear channel 1 without overlap.
        load_sy(8'h20); frame();
        car = 2'b10; line(6, 1'b1); idle(4);
        chk("skid_set", skid, 2'b10);
        chk("crash_on_skid_row", crash, 2'b00);
        car = 2'b00; clr = 2'b01; step(); clr = 2'b11;
        chk("skid_cleared", skid, 2'b00);

        // Window closed over crash tiles.
        load_sy(8'h10); frame();
        car = 2'b11; line(8, 1'b0); idle(4); car = 2'b00;
        chk("no_crash_window_off", crash, 2'b00);
        chk("no_skid_window_off", skid, 2'b00);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            php_n = ($urandom_range(0, 19) != 0);
            pvp_n = ($urandom_range(0, 19) != 0);
            bd    = 8'($urandom);
            ls    = ($urandom_range(0, 15) == 0);
            fs    = ($urandom_range(0, 199) == 0);
            act   = ($urandom_range(0, 3) != 0);
            win   = ($urandom_range(0, 4) != 0);
            car   = 2'($urandom);
            clr   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
            step();
        end
        idle_inputs(); idle(4);

        // Reset asserted mid-frame while playfield and flags are live.
        load_sy(8'h10); frame();
        car = 2'b01; line(6, 1'b1);
        act = 1'b1; step();
        #2; rst_n = 1'b0; in_reset = 1'b1;
        #1;
        chk("rst_pix", pix, 2'b00);
        chk("rst_pfld", pfld, 1'b0);
        chk("rst_wndo", wndo, 1'b0);
        chk("rst_pcc", pcc, 2'b00);
        chk("rst_crash", crash, 2'b00);
        chk("rst_skid", skid, 2'b00);
        chk("rst_map_adr", map_adr, 8'h00);
        do_reset();
        idle(2);
        line(5, 1'b1); idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, got %0d checks expected completion", n_checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
